// File: rtl/cache_refill_memory_pkg.sv
// Shared types and default sizing for the cache refill memory model.
// Derived widths are exported here so sub-blocks and benches agree on them.
package cache_refill_memory_pkg;

  localparam int ADDR_W             = 32;
  localparam int DATA_W             = 32;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int DEF_MEM_DEPTH      = 1024;
  localparam int DEF_LATENCY        = 4;

  localparam int OFF_W = $clog2(DEF_WORDS_PER_LINE);
  localparam int IDX_W = $clog2(DEF_MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/cache_refill_memory_mem_array.sv
// Single-port word storage: combinational read, synchronous write.
// Contents are deliberately never reset.
module refill_mem_array
  import cache_refill_memory_pkg::*;
#(
  parameter int DEPTH  = DEF_MEM_DEPTH,
  parameter int AW     = $clog2(DEPTH),
  parameter int WIDTH  = DATA_W
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/cache_refill_memory.sv
// Miss-side memory responder: one request at a time, fixed latency, then either
// a critical-word-first line burst or a single-word write commit.
module cache_refill_memory
  import cache_refill_memory_pkg::*;
#(
  parameter  int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter  int MEM_DEPTH      = DEF_MEM_DEPTH,
  parameter  int LATENCY        = DEF_LATENCY,
  localparam int L_OFF_W        = $clog2(WORDS_PER_LINE),
  localparam int L_IDX_W        = $clog2(MEM_DEPTH),
  localparam int CNT_W          = (LATENCY > 1) ? $clog2(LATENCY) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               resp_valid,
  output logic [DATA_W-1:0]  resp_data,
  output logic [L_OFF_W-1:0] resp_beat,
  output logic               resp_last,
  output logic               wr_ack,
  output logic               busy
);

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [L_OFF_W-1:0]   r_beat;
  logic [L_IDX_W-1:0]   r_idx;
  logic                 r_write;
  logic [DATA_W-1:0]    r_wdata;

  logic [L_OFF_W-1:0]   w_beat_off;
  logic [L_IDX_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]    w_rd_data;
  logic                 w_unused;

  // Byte-offset bits and bits above the word index are intentionally dropped (aliasing).
  assign w_unused = ^{req_addr[ADDR_W-1:2+L_IDX_W], req_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_beat  <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_beat  <= '0;
            r_idx   <= req_addr[2 +: L_IDX_W];
            r_write <= req_write;
            r_wdata <= req_wdata;
          end
        end
        ST_WAIT: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        ST_BURST: r_beat <= r_beat + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (req_valid) w_state_next = ST_WAIT;
      ST_WAIT:  if (r_cnt == '0) w_state_next = r_write ? ST_WRITE : ST_BURST;
      ST_BURST: if (r_beat == L_OFF_W'(WORDS_PER_LINE - 1)) w_state_next = ST_IDLE;
      ST_WRITE: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Offset arithmetic wraps naturally at the line size since it is OFF_W bits wide.
  assign w_beat_off = r_idx[L_OFF_W-1:0] + r_beat;
  assign w_mem_addr = (r_state == ST_WRITE) ? r_idx
                                            : {r_idx[L_IDX_W-1:L_OFF_W], w_beat_off};

  refill_mem_array #(
    .DEPTH (MEM_DEPTH),
    .AW    (L_IDX_W),
    .WIDTH (DATA_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (r_state == ST_WRITE),
    .i_addr  (w_mem_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_rd_data)
  );

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign resp_valid = (r_state == ST_BURST);
  assign resp_data  = resp_valid ? w_rd_data : '0;
  assign resp_beat  = resp_valid ? w_beat_off : '0;
  assign resp_last  = resp_valid && (r_beat == L_OFF_W'(WORDS_PER_LINE - 1));
  assign wr_ack     = (r_state == ST_WRITE);

endmodule

// File: tb/tb_cache_refill_memory.sv
// Directed bench for cache_refill_memory: writes, refills, wrap order, aliasing,
// busy rejection and asynchronous reset during a burst.
module tb_cache_refill_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_beat;
  logic        resp_last;
  logic        wr_ack;
  logic        busy;

  int tests = 0;
  int fails = 0;

  cache_refill_memory dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_beat  (resp_beat),
    .resp_last  (resp_last),
    .wr_ack     (wr_ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    int cnt;
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data;
    @(negedge clk);
    check("wr_accept_busy", {31'b0, busy}, 32'd1);
    req_valid = 1'b0; req_write = 1'b0;
    cnt = 0;
    while (!wr_ack && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("wr_ack_latency", cnt, 32'd4);
    @(negedge clk);
    check("wr_ack_single_pulse", {31'b0, wr_ack}, 32'd0);
    check("wr_ready_after", {31'b0, req_ready}, 32'd1);
    $display("[TB] write addr=%h data=%h ack_after=%0d", addr, data, cnt);
  endtask

  // d = {beat3, beat2, beat1, beat0}, b likewise 2 bits per beat, m masks data checks
  task automatic collect_read(input string tag, input logic [127:0] d,
                              input logic [7:0] b, input logic [3:0] m);
    int cnt;
    cnt = 0;
    while (!resp_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_latency"}, cnt, 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (m[k]) check({tag, "_data"}, resp_data, d[32*k +: 32]);
      check({tag, "_beat"}, {30'b0, resp_beat}, {30'b0, b[2*k +: 2]});
      check({tag, "_last"}, {31'b0, resp_last}, {31'b0, (k == 3)});
      check({tag, "_ready_low"}, {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    check({tag, "_valid_off"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_data_zero"}, resp_data, 32'd0);
    check({tag, "_ready_back"}, {31'b0, req_ready}, 32'd1);
    $display("[TB] read %s latency=%0d", tag, cnt);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_wr_ack", {31'b0, wr_ack}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_beat", {30'b0, resp_beat}, 32'd0);
    check("rst_resp_last", {31'b0, resp_last}, 32'd0);
    $display("[TB] reset released");

    // Preload words 0x10..0x13 with 0xA0000000 + word index
    for (int w = 16; w < 20; w++) do_write(32'(w * 4), 32'hA000_0000 + 32'(w));

    // Aligned refill
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40;
    @(negedge clk);
    check("aligned_accept", {31'b0, busy}, 32'd1);
    req_valid = 1'b0;
    collect_read("aligned", {32'hA000_0013, 32'hA000_0012, 32'hA000_0011, 32'hA000_0010},
                 {2'd3, 2'd2, 2'd1, 2'd0}, 4'b1111);

    // Critical word wrap
    req_valid = 1'b1; req_addr = 32'h4C;
    @(negedge clk);
    check("wrap_accept", {31'b0, busy}, 32'd1);
    req_valid = 1'b0;
    collect_read("wrap", {32'hA000_0012, 32'hA000_0011, 32'hA000_0010, 32'hA000_0013},
                 {2'd2, 2'd1, 2'd0, 2'd3}, 4'b1111);

    // Write then read the line back
    do_write(32'h104, 32'hDEAD_BEEF);
    req_valid = 1'b1; req_addr = 32'h100;
    @(negedge clk);
    check("wb_accept", {31'b0, busy}, 32'd1);
    req_valid = 1'b0;
    collect_read("write_back", {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0},
                 {2'd3, 2'd2, 2'd1, 2'd0}, 4'b0010);

    // Aliased read, with a second request held (new address) while busy
    req_valid = 1'b1; req_addr = 32'h1040;
    @(negedge clk);
    check("alias_accept", {31'b0, busy}, 32'd1);
    req_addr = 32'h4C;
    collect_read("alias", {32'hA000_0013, 32'hA000_0012, 32'hA000_0011, 32'hA000_0010},
                 {2'd3, 2'd2, 2'd1, 2'd0}, 4'b1111);
    @(negedge clk);
    check("held_accept", {31'b0, busy}, 32'd1);
    req_valid = 1'b0;
    collect_read("held", {32'hA000_0012, 32'hA000_0011, 32'hA000_0010, 32'hA000_0013},
                 {2'd2, 2'd1, 2'd0, 2'd3}, 4'b1111);

    // Reset during beat 1
    req_valid = 1'b1; req_addr = 32'h40;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    while (!resp_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("midrst_latency", cnt, 32'd4);
    @(negedge clk);
    check("midrst_beat1", {30'b0, resp_beat}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'b0, resp_valid}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_ready", {31'b0, req_ready}, 32'd1);
    check("midrst_data", resp_data, 32'd0);
    check("midrst_beat", {30'b0, resp_beat}, 32'd0);
    $display("[TB] reset asserted mid-burst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h4C;
    @(negedge clk);
    check("post_rst_accept", {31'b0, busy}, 32'd1);
    req_valid = 1'b0;
    collect_read("post_rst", {32'hA000_0012, 32'hA000_0011, 32'hA000_0010, 32'hA000_0013},
                 {2'd2, 2'd1, 2'd0, 2'd3}, 4'b1111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
